// File: rtl/pattern_scan_ctrl.sv
// rtl/pattern_scan_ctrl.sv - word-to-bit-serial pattern match sequencer (optional MATCH_CARRY_EN carries history across words)
module pattern_scan_ctrl #(
    parameter int WIDTH   = 16,
    parameter int PAT_LEN = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    input  logic [PAT_LEN-1:0]           cfg_pattern,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_hit,
    output logic [$clog2(WIDTH+1)-1:0]   out_count,
    output logic [$clog2(WIDTH+1)-1:0]   out_first,
    output logic                         busy
);

    localparam int CNT_W  = $clog2(WIDTH + 1);
    localparam int FILL_W = $clog2(PAT_LEN + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    shreg_q, shreg_d;
    logic [PAT_LEN-1:0]  pat_q, pat_d;
    logic [PAT_LEN-1:0]  hist_q, hist_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic [CNT_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [CNT_W-1:0]    first_q, first_d;
    logic                hitflag_q, hitflag_d;
    logic                out_valid_q, out_valid_d;
    logic                out_hit_q, out_hit_d;
    logic [CNT_W-1:0]    out_count_q, out_count_d;
    logic [CNT_W-1:0]    out_first_q, out_first_d;

    // Datapath helpers for the bit being shifted this cycle
    logic                bit_in;
    logic [PAT_LEN-1:0]  hist_shift;
    logic [FILL_W-1:0]   fill_inc;
    logic                match;
    logic [CNT_W-1:0]    count_next;
    logic [CNT_W-1:0]    first_next;
    logic                hit_next;

    // Next history/fill and match decision for the current shift step
    always_comb begin
        bit_in     = shreg_q[WIDTH-1];
        hist_shift = {hist_q[PAT_LEN-2:0], bit_in};
        if (fill_q == FILL_W'(PAT_LEN)) begin
            fill_inc = fill_q;
        end else begin
            fill_inc = fill_q + FILL_W'(1);
        end
        match      = (hist_shift == pat_q) && (fill_inc == FILL_W'(PAT_LEN));
        count_next = count_q + {{(CNT_W-1){1'b0}}, match};
        first_next = first_q;
        hit_next   = hitflag_q;
        if (match && !hitflag_q) begin
            first_next = idx_q;
            hit_next   = 1'b1;
        end
    end

    // FSM next-state and register next values
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        pat_d       = pat_q;
        hist_d      = hist_q;
        fill_d      = fill_q;
        idx_d       = idx_q;
        count_d     = count_q;
        first_d     = first_q;
        hitflag_d   = hitflag_q;
        out_valid_d = out_valid_q;
        out_hit_d   = out_hit_q;
        out_count_d = out_count_q;
        out_first_d = out_first_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    shreg_d   = in_data;
                    pat_d     = cfg_pattern;
                    idx_d     = '0;
                    count_d   = '0;
                    first_d   = '0;
                    hitflag_d = 1'b0;
`ifdef MATCH_CARRY_EN
                    // history survives acceptance so matches may span words
`else
                    hist_d    = '0;
                    fill_d    = '0;
`endif
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                shreg_d   = shreg_q << 1;
                hist_d    = hist_shift;
                fill_d    = fill_inc;
                count_d   = count_next;
                first_d   = first_next;
                hitflag_d = hit_next;
                if (idx_q == CNT_W'(WIDTH - 1)) begin
                    out_valid_d = 1'b1;
                    out_hit_d   = hit_next;
                    out_count_d = count_next;
                    out_first_d = first_next;
                    state_d     = S_DONE;
                end else begin
                    idx_d = idx_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, asynchronously cleared
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            shreg_q     <= '0;
            pat_q       <= '0;
            hist_q      <= '0;
            fill_q      <= '0;
            idx_q       <= '0;
            count_q     <= '0;
            first_q     <= '0;
            hitflag_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_hit_q   <= 1'b0;
            out_count_q <= '0;
            out_first_q <= '0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            pat_q       <= pat_d;
            hist_q      <= hist_d;
            fill_q      <= fill_d;
            idx_q       <= idx_d;
            count_q     <= count_d;
            first_q     <= first_d;
            hitflag_q   <= hitflag_d;
            out_valid_q <= out_valid_d;
            out_hit_q   <= out_hit_d;
            out_count_q <= out_count_d;
            out_first_q <= out_first_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = out_valid_q;
    assign out_hit   = out_hit_q;
    assign out_count = out_count_q;
    assign out_first = out_first_q;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// tb/tb_pattern_scan_ctrl.sv - randomized self-checking bench for pattern_scan_ctrl
module tb_pattern_scan_ctrl;

    localparam int WIDTH   = 16;
    localparam int PAT_LEN = 4;
    localparam int CNT_W   = $clog2(WIDTH + 1);

    logic               clk;
    logic               reset_n;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic [PAT_LEN-1:0] cfg_pattern;
    logic               out_valid;
    logic               out_ready;
    logic               out_hit;
    logic [CNT_W-1:0]   out_count;
    logic [CNT_W-1:0]   out_first;
    logic               busy;

    int vec_cnt  = 0;
    int miscmp   = 0;

    bit m_hist[$];

    pattern_scan_ctrl #(.WIDTH(WIDTH), .PAT_LEN(PAT_LEN)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .cfg_pattern (cfg_pattern),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_hit     (out_hit),
        .out_count   (out_count),
        .out_first   (out_first),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the bit stream as a sliding window of the last PAT_LEN bits
    task automatic model_word(input logic [WIDTH-1:0] d, input logic [PAT_LEN-1:0] p,
                              output logic h, output int c, output int f);
        bit ok;
`ifndef MATCH_CARRY_EN
        m_hist.delete();
`endif
        h = 1'b0; c = 0; f = 0;
        for (int i = 0; i < WIDTH; i++) begin
            m_hist.push_back(d[WIDTH-1-i]);
            if (m_hist.size() > PAT_LEN) void'(m_hist.pop_front());
            if (m_hist.size() == PAT_LEN) begin
                ok = 1'b1;
                for (int j = 0; j < PAT_LEN; j++)
                    if (m_hist[j] != p[PAT_LEN-1-j]) ok = 1'b0;
                if (ok) begin
                    c++;
                    if (!h) begin h = 1'b1; f = i; end
                end
            end
        end
    endtask

    // Drives one word, waits for its result, then completes the output handshake
    task automatic run_word(input logic [WIDTH-1:0] d, input logic [PAT_LEN-1:0] p,
                            output logic h, output int c, output int f, output int lat);
        in_valid = 1'b1; in_data = d; cfg_pattern = p;
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = WIDTH'($urandom); cfg_pattern = PAT_LEN'($urandom);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        h = out_hit; c = int'(out_count); f = int'(out_first);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; cfg_pattern = '0;
        repeat (3) @(posedge clk);
        #1;
        vec_cnt++; if (in_ready !== 1'b1) begin miscmp++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        vec_cnt++; if (out_valid !== 1'b0) begin miscmp++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        vec_cnt++; if (busy !== 1'b0) begin miscmp++; $display("FAIL reset_busy got %b want 0", busy); end
        vec_cnt++; if ({out_hit, out_count, out_first} !== '0) begin miscmp++;
            $display("FAIL reset_outputs got hit=%b cnt=%0d first=%0d want 0/0/0", out_hit, out_count, out_first); end
        m_hist.delete();
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [WIDTH-1:0] dv [3] = '{16'hD000, 16'hDB00, 16'h0000};
        logic             eh [3] = '{1'b1, 1'b1, 1'b0};
        int               ec [3] = '{1, 2, 0};
        int               ef [3] = '{3, 3, 0};
        logic h, mh; int c, f, lat, mc, mf;
        for (int k = 0; k < 3; k++) begin
            model_word(dv[k], 4'b1101, mh, mc, mf);
            run_word(dv[k], 4'b1101, h, c, f, lat);
            vec_cnt++; if (lat !== WIDTH) begin miscmp++; $display("FAIL dir_latency[%0d] got %0d want %0d", k, lat, WIDTH); end
            vec_cnt++; if (h !== eh[k] || c !== ec[k] || f !== ef[k]) begin miscmp++;
                $display("FAIL dir_result[%0d] got hit=%b cnt=%0d first=%0d want %b/%0d/%0d", k, h, c, f, eh[k], ec[k], ef[k]); end
            vec_cnt++; if (h !== mh || c !== mc || f !== mf) begin miscmp++;
                $display("FAIL dir_model[%0d] got %b/%0d/%0d model %b/%0d/%0d", k, h, c, f, mh, mc, mf); end
        end
    endtask

    task automatic test_backpressure();
        logic h, mh; int lat, mc, mf;
        logic [CNT_W-1:0] sc, sf; logic sh;
        model_word(16'hD000, 4'b1101, mh, mc, mf);
        in_valid = 1'b1; in_data = 16'hD000; cfg_pattern = 4'b1101;
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 16'h0D00; cfg_pattern = 4'b1101;
        lat = 0;
        while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        vec_cnt++; if (lat !== WIDTH) begin miscmp++; $display("FAIL bp_latency got %0d want %0d", lat, WIDTH); end
        sh = out_hit; sc = out_count; sf = out_first;
        vec_cnt++; if (sh !== mh || int'(sc) !== mc || int'(sf) !== mf) begin miscmp++;
            $display("FAIL bp_result got %b/%0d/%0d want %b/%0d/%0d", sh, sc, sf, mh, mc, mf); end
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            vec_cnt++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin miscmp++;
                $display("FAIL bp_hold[%0d] got valid=%b ready=%b want 1/0", k, out_valid, in_ready); end
            vec_cnt++; if (out_hit !== sh || out_count !== sc || out_first !== sf) begin miscmp++;
                $display("FAIL bp_stable[%0d] got %b/%0d/%0d want %b/%0d/%0d", k, out_hit, out_count, out_first, sh, sc, sf); end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        vec_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin miscmp++;
            $display("FAIL bp_idle got valid=%b ready=%b busy=%b want 0/1/0", out_valid, in_ready, busy); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        vec_cnt++; if (busy !== 1'b1 || in_ready !== 1'b0) begin miscmp++;
            $display("FAIL bp_pending_accept got busy=%b ready=%b want 1/0", busy, in_ready); end
        model_word(16'h0D00, 4'b1101, mh, mc, mf);
        lat = 0;
        while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        h = out_hit;
        vec_cnt++; if (lat !== WIDTH || h !== mh || int'(out_count) !== mc || int'(out_first) !== mf) begin miscmp++;
            $display("FAIL bp_pending_result got lat=%0d %b/%0d/%0d want %0d %b/%0d/%0d", lat, h, out_count, out_first, WIDTH, mh, mc, mf); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_abort();
        logic h, mh; int c, f, lat, mc, mf;
        in_valid = 1'b1; in_data = 16'hD000; cfg_pattern = 4'b1101;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        vec_cnt++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin miscmp++;
            $display("FAIL abort_state got valid=%b busy=%b ready=%b want 0/0/1", out_valid, busy, in_ready); end
        m_hist.delete();
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        vec_cnt++; if (out_valid !== 1'b0) begin miscmp++; $display("FAIL abort_no_result got %b want 0", out_valid); end
        model_word(16'hD000, 4'b1101, mh, mc, mf);
        run_word(16'hD000, 4'b1101, h, c, f, lat);
        vec_cnt++; if (h !== 1'b1 || c !== 1 || f !== 3 || lat !== WIDTH) begin miscmp++;
            $display("FAIL abort_next got lat=%0d %b/%0d/%0d want %0d 1/1/3", lat, h, c, f, WIDTH); end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] d; logic [PAT_LEN-1:0] p;
        logic h, mh; int c, f, lat, mc, mf;
        for (int k = 0; k < 40; k++) begin
            p = PAT_LEN'($urandom);
            d = WIDTH'($urandom);
            if (k % 3 == 0) d = {p, p, p, p} ^ WIDTH'(1 << $urandom_range(0, WIDTH-1));
            model_word(d, p, mh, mc, mf);
            run_word(d, p, h, c, f, lat);
            vec_cnt++; if (lat !== WIDTH || h !== mh || c !== mc || f !== mf) begin miscmp++;
                $display("FAIL rand[%0d] d=%h p=%b got lat=%0d %b/%0d/%0d want %0d %b/%0d/%0d",
                         k, d, p, lat, h, c, f, WIDTH, mh, mc, mf); end
        end
    endtask

    task automatic test_carry();
        logic h, mh; int c, f, lat, mc, mf;
        logic eh; int ec, ef;
`ifdef MATCH_CARRY_EN
        eh = 1'b1; ec = 1; ef = 0;
`else
        eh = 1'b0; ec = 0; ef = 0;
`endif
        model_word(16'h0006, 4'b1101, mh, mc, mf);
        run_word(16'h0006, 4'b1101, h, c, f, lat);
        vec_cnt++; if (h !== mh || c !== mc || f !== mf) begin miscmp++;
            $display("FAIL carry_first got %b/%0d/%0d want %b/%0d/%0d", h, c, f, mh, mc, mf); end
        model_word(16'h8000, 4'b1101, mh, mc, mf);
        run_word(16'h8000, 4'b1101, h, c, f, lat);
        vec_cnt++; if (h !== eh || c !== ec || f !== ef) begin miscmp++;
            $display("FAIL carry_second got %b/%0d/%0d want %b/%0d/%0d", h, c, f, eh, ec, ef); end
        vec_cnt++; if (h !== mh || c !== mc || f !== mf) begin miscmp++;
            $display("FAIL carry_model got %b/%0d/%0d model %b/%0d/%0d", h, c, f, mh, mc, mf); end
    endtask

    task automatic test_back_to_back();
        logic mh; int mc, mf;
        int n, acc0, acc1, naccept;
        logic prev_ready;
        out_ready = 1'b1; in_valid = 1'b1; in_data = 16'hDB00; cfg_pattern = 4'b1101;
        prev_ready = in_ready;
        n = 0; acc0 = -1; acc1 = -1; naccept = 0;
        while (naccept < 2 && n < 100) begin
            @(posedge clk); #1; n++;
            if (prev_ready && !in_ready) begin
                model_word(16'hDB00, 4'b1101, mh, mc, mf);
                if (naccept == 0) acc0 = n; else acc1 = n;
                naccept++;
                if (naccept == 2) in_valid = 1'b0;
            end
            prev_ready = in_ready;
        end
        vec_cnt++; if (acc1 - acc0 !== WIDTH + 2) begin miscmp++;
            $display("FAIL b2b_period got %0d want %0d", acc1 - acc0, WIDTH + 2); end
        n = 0;
        while (busy && n < 60) begin @(posedge clk); #1; n++; end
        vec_cnt++; if (busy !== 1'b0) begin miscmp++; $display("FAIL b2b_drain got busy=%b want 0", busy); end
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_abort();
        test_random();
        test_carry();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
        $finish;
    end

endmodule
